// File: rtl/rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : rr_arbiter_if
// Description: Handshake bundle between N requesters, the round-robin arbiter
//              and one downstream consumer.
//              master : requester/consumer side (drives requests, out_ready)
//              slave  : arbiter side (drives in_ready and the output stage)
// Signals    : in_valid  [N]        per-requester request valid
//              in_data   [N][DATAW] payload, element i owned by requester i
//              in_ready  [N]        one-hot-or-zero accept strobe
//              out_valid            output stage holds a transfer
//              out_data  [DATAW]    registered payload
//              out_id    [IDW]      requester index owning out_data
//              out_ready            downstream accept
// Revision   : 1.0 - initial release
// ============================================================================
interface rr_arbiter_if #(
   parameter int DATAW = 32,
   parameter int N     = 4,
   parameter int IDW   = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]            in_valid;
   logic [N-1:0][DATAW-1:0] in_data;
   logic [N-1:0]            in_ready;
   logic                    out_valid;
   logic [DATAW-1:0]        out_data;
   logic [IDW-1:0]          out_id;
   logic                    out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_id
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_id
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rr_arbiter
// Description: Round-robin arbiter sharing one downstream consumer between N
//              valid/ready requesters. One requester wins per accept, its data
//              is steered through an N:1 mux into a single-entry output stage.
//              Drain and refill may happen in the same cycle, so throughput is
//              one item per cycle while out_ready stays high.
// Ports      : clk   - rising-edge clock
//              rstn  - synchronous active-low reset
//              bus   - rr_arbiter_if.slave (requests in, registered item out)
// Revision   : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int DATAW = 32,
   parameter int N     = 4
) (
   input  logic         clk,
   input  logic         rstn,
   rr_arbiter_if.slave  bus
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state;
   logic [IDW-1:0]     ptr;
   logic [DATAW-1:0]   data_q;
   logic [IDW-1:0]     id_q;

   logic               win_found;
   logic [IDW-1:0]     win_idx;
   logic [IDW-1:0]     ptr_next;
   logic [IDW:0]       cand;
   logic               can_accept;
   logic               accept;
   logic [N-1:0]       ready_vec;

   // ------------------------------------------------------------------------
   // Winner search: first valid requester starting at ptr, wrapping at N.
   // cand carries one extra bit so ptr+k never overflows before the wrap.
   // ------------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) begin
            cand = cand - (IDW+1)'(N);
         end
         if (!win_found && bus.in_valid[cand[IDW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDW-1:0];
         end
      end
   end

   // The output stage can take a new item when empty, or when the held item
   // leaves this same cycle.
   assign can_accept = (state == EMPTY) || bus.out_ready;
   assign accept     = rstn && can_accept && win_found;

   // Pointer moves one past the winner so it gets lowest priority next time.
   assign ptr_next = (win_idx == IDW'(N-1)) ? '0 : (win_idx + IDW'(1));

   always_comb begin
      ready_vec = '0;
      if (accept) begin
         ready_vec[win_idx] = 1'b1;
      end
   end

   assign bus.in_ready = ready_vec;

   // ------------------------------------------------------------------------
   // Output stage FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= EMPTY;
         ptr    <= '0;
         data_q <= '0;
         id_q   <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state  <= FULL;
                  data_q <= bus.in_data[win_idx];
                  id_q   <= win_idx;
                  ptr    <= ptr_next;
               end
            end
            FULL: begin
               if (accept) begin
                  // drain and refill in one cycle
                  data_q <= bus.in_data[win_idx];
                  id_q   <= win_idx;
                  ptr    <= ptr_next;
               end else if (bus.out_ready) begin
                  state <= EMPTY;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_id    = id_q;

   // ------------------------------------------------------------------------
   // Protocol checks
   // ------------------------------------------------------------------------
   // A request that is not accepted must be held with unchanged data.
   for (genvar i = 0; i < N; i++) begin : g_contract
      a_hold_request : assert property (
         @(posedge clk) disable iff (!rstn)
         (bus.in_valid[i] && !bus.in_ready[i]) |=>
            (bus.in_valid[i] && $stable(bus.in_data[i]))
      );
   end

   // At most one accept strobe, and only towards a valid requester.
   a_ready_onehot : assert property (
      @(posedge clk)
      $onehot0(bus.in_ready) && ((bus.in_ready & ~bus.in_valid) == '0)
   );

endmodule
`default_nettype wire
